// File: rtl/alu_result_monitor.sv
// Watches the mini ALU's outputs, captures one settled result per function code,
// folds each capture into an 8-bit MISR and flags repeats that disagree with the store.
module alu_result_monitor #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] alu_fxn,
  input  logic [5:0] alu_out,
  input  logic       alu_o_flow,
  input  logic       alu_c_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] seen_mask,
  output logic [7:0] signature,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] SETTLE_CNT  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]  state_reg, state_next;
  logic [10:0] tuple, sample_reg;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  mask_reg, mask_next;
  logic [7:0]  sig_reg, sig_next;
  logic        error_reg, error_next;
  logic [7:0]  rd_data_reg;
  logic [7:0]  store_reg [8];
  logic [7:0]  word, code_bit, wr_en;
  logic        armed, settle, capture, repeat_bad;

  assign tuple = {alu_fxn, alu_o_flow, alu_c_out, alu_out};
  assign word  = {alu_o_flow, alu_c_out, alu_out};
  assign armed = (state_reg == ARMED);

  // The settle event fires exactly once per stable tuple; start suppresses it.
  assign settle     = armed && !start && (tuple == sample_reg) && (cnt_reg == SETTLE_LAST);
  assign capture    = settle && !mask_reg[alu_fxn];
  assign repeat_bad = settle && mask_reg[alu_fxn] && (store_reg[alu_fxn] != word);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign code_bit[gi] = (alu_fxn == 3'(gi));
      assign wr_en[gi]    = capture && code_bit[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mask_next  = mask_reg;
    sig_next   = sig_reg;
    error_next = error_reg;
    if (start) begin
      state_next = ARMED;
      cnt_next   = '0;
      mask_next  = '0;
      sig_next   = '0;
      error_next = 1'b0;
    end else if (armed) begin
      if (tuple != sample_reg) begin
        cnt_next = '0;
      end else if (cnt_reg < SETTLE_CNT) begin
        cnt_next = cnt_reg + 4'd1;
      end
      if (capture) begin
        mask_next = mask_reg | wr_en;
        sig_next  = {sig_reg[6:0], sig_reg[7] ^ sig_reg[5] ^ sig_reg[4] ^ sig_reg[3]} ^ word;
        if ((mask_reg | wr_en) == 8'hFF) begin
          state_next = DONE;
        end
      end
      if (repeat_bad) begin
        error_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sample_reg <= '0;
      cnt_reg    <= '0;
      mask_reg   <= '0;
      sig_reg    <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mask_reg  <= mask_next;
      sig_reg   <= sig_next;
      error_reg <= error_next;
      if (start || armed) begin
        sample_reg <= tuple;
      end
    end
  end

  // Read returns the pre-write word when read and capture hit the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        store_reg[i] <= '0;
      end
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= store_reg[rd_addr];
      for (int i = 0; i < 8; i++) begin
        if (start) begin
          store_reg[i] <= '0;
        end else if (wr_en[i]) begin
          store_reg[i] <= word;
        end
      end
    end
  end

  assign busy      = armed;
  assign done      = (state_reg == DONE);
  assign error     = error_reg;
  assign seen_mask = mask_reg;
  assign signature = sig_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Self-checking bench for alu_result_monitor: directed sequences, a sweep table and
// random tuples, all compared every cycle against a run-length based reference model.
module tb_alu_result_monitor;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] alu_fxn = '0;
  logic [5:0] alu_out = '0;
  logic       alu_o_flow = 1'b0;
  logic       alu_c_out = 1'b0;
  logic [2:0] rd_addr = '0;
  logic       busy, done, error;
  logic [7:0] seen_mask, signature, rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_monitor #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_fxn(alu_fxn), .alu_out(alu_out), .alu_o_flow(alu_o_flow), .alu_c_out(alu_c_out),
    .busy(busy), .done(done), .error(error),
    .seen_mask(seen_mask), .signature(signature),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Reference model: a capture happens when the same tuple has been seen on
  // SETTLE+1 consecutive armed edges (the start edge begins a new run).
  typedef enum int {M_IDLE, M_ARMED, M_DONE} mstate_t;
  mstate_t     m_state;
  logic [7:0]  m_store [8];
  logic [7:0]  m_mask, m_sig, m_rd;
  logic        m_err;
  logic [10:0] m_prev;
  int          m_run;

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] w);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ w;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    for (int i = 0; i < 8; i++) m_store[i] = 8'h00;
    m_mask = 8'h00; m_sig = 8'h00; m_rd = 8'h00; m_err = 1'b0;
    m_prev = '0; m_run = 0;
  endtask

  task automatic model_update();
    logic [10:0] t;
    logic [7:0]  w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t = {alu_fxn, alu_o_flow, alu_c_out, alu_out};
    w = {alu_o_flow, alu_c_out, alu_out};
    m_rd = m_store[rd_addr];
    if (start) begin
      for (int i = 0; i < 8; i++) m_store[i] = 8'h00;
      m_mask = 8'h00; m_sig = 8'h00; m_err = 1'b0;
      m_state = M_ARMED; m_prev = t; m_run = 1;
    end else if (m_state == M_ARMED) begin
      m_run  = (t == m_prev) ? m_run + 1 : 1;
      m_prev = t;
      if (m_run == SETTLE + 1) begin
        if (!m_mask[alu_fxn]) begin
          m_store[alu_fxn] = w;
          m_mask[alu_fxn]  = 1'b1;
          m_sig = misr(m_sig, w);
          if (m_mask == 8'hFF) m_state = M_DONE;
        end else if (m_store[alu_fxn] != w) begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic compare_all();
    check("busy",  {7'd0, busy},  {7'd0, m_state == M_ARMED});
    check("done",  {7'd0, done},  {7'd0, m_state == M_DONE});
    check("error", {7'd0, error}, {7'd0, m_err});
    check("seen_mask", seen_mask, m_mask);
    check("signature", signature, m_sig);
    check("rd_data",   rd_data,   m_rd);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_tuple(input logic [2:0] f, input logic [7:0] w);
    alu_fxn = f;
    {alu_o_flow, alu_c_out, alu_out} = w;
  endtask

  task automatic hold(input logic [2:0] f, input logic [7:0] w, input int n);
    set_tuple(f, w);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0] fxn;
    logic [7:0] word;
    logic [7:0] exp_mask;
    logic       exp_done;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] exp_sig;
  logic [7:0] rw;
  int         len;

  initial begin
    tbl[0] = '{3'd2, 8'h3C, 8'h04, 1'b0};
    tbl[1] = '{3'd5, 8'hC1, 8'h24, 1'b0};
    tbl[2] = '{3'd0, 8'h5A, 8'h25, 1'b0};
    tbl[3] = '{3'd7, 8'h96, 8'hA5, 1'b0};
    tbl[4] = '{3'd1, 8'h0F, 8'hA7, 1'b0};
    tbl[5] = '{3'd4, 8'hE7, 8'hB7, 1'b0};
    tbl[6] = '{3'd6, 8'h42, 8'hF7, 1'b0};
    tbl[7] = '{3'd3, 8'hBD, 8'hFF, 1'b1};

    // Reset defaults
    #1 rst_n = 1'b0;
    model_reset();
    step();
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_mask", seen_mask, 8'h00);
    check("reset_sig",  signature, 8'h00);
    check("reset_rd",   rd_data,   8'h00);
    rst_n = 1'b1;
    step();

    // Single capture with a short hold and a glitch before it
    set_tuple(3'd3, 8'hA5);
    pulse_start();
    repeat (3) step();
    check("short_hold_mask", seen_mask, 8'h00);
    set_tuple(3'd3, 8'hA4);
    step();
    set_tuple(3'd3, 8'hA5);
    repeat (4) step();
    check("glitch_wait_mask", seen_mask, 8'h00);
    step();
    check("single_mask", seen_mask, 8'h08);
    check("single_sig",  signature, 8'hA5);
    rd_addr = 3'd3;
    step();
    check("single_rd", rd_data, 8'hA5);
    $display("single capture: mask %h sig %h rd %h", seen_mask, signature, rd_data);

    // Repeat presentations of code 3
    hold(3'd1, 8'h11, 1);
    hold(3'd3, 8'hA5, 5);
    check("repeat_same_err",  {7'd0, error}, 8'h00);
    check("repeat_same_mask", seen_mask, 8'h08);
    hold(3'd3, 8'hA4, 5);
    check("repeat_diff_err", {7'd0, error}, 8'h01);
    check("repeat_diff_rd",  rd_data, 8'hA5);
    $display("repeat code 3: error %0d stored %h", error, rd_data);

    // start on the same edge as a settle event
    set_tuple(3'd5, 8'h5A);
    pulse_start();
    repeat (3) step();
    pulse_start();
    check("collide_mask", seen_mask, 8'h00);
    check("collide_sig",  signature, 8'h00);
    check("collide_busy", {7'd0, busy},  8'h01);
    check("collide_err",  {7'd0, error}, 8'h00);
    repeat (4) step();
    check("after_collide_mask", seen_mask, 8'h20);
    $display("start collision: mask %h busy %0d", seen_mask, busy);

    // Full sweep in scrambled code order
    pulse_start();
    exp_sig = 8'h00;
    for (int i = 0; i < 8; i++) begin
      hold(tbl[i].fxn, tbl[i].word, 5);
      exp_sig = misr(exp_sig, tbl[i].word);
      check("sweep_mask", seen_mask, tbl[i].exp_mask);
      check("sweep_done", {7'd0, done}, {7'd0, tbl[i].exp_done});
      check("sweep_busy", {7'd0, busy}, {7'd0, !tbl[i].exp_done});
      $display("sweep code %0d word %h: mask %h sig %h done %0d",
               tbl[i].fxn, tbl[i].word, seen_mask, signature, done);
    end
    check("sweep_sig", signature, exp_sig);

    // Inputs ignored in DONE
    for (int i = 0; i < 10; i++) begin
      rw = 8'($urandom);
      set_tuple(3'($urandom_range(0, 7)), rw);
      step();
    end
    check("done_hold_mask", seen_mask, 8'hFF);
    check("done_hold_sig",  signature, exp_sig);
    check("done_hold_done", {7'd0, done}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      rd_addr = tbl[i].fxn;
      step();
      check("readback", rd_data, tbl[i].word);
    end

    // Randomized tuples with random hold lengths and occasional restarts
    pulse_start();
    for (int s = 0; s < 80; s++) begin
      len = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
        0: rw = 8'hA5;
        1: rw = 8'hA4;
        2: rw = 8'h3C;
        default: rw = 8'h00;
      endcase
      set_tuple(3'($urandom_range(0, 7)), rw);
      start = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < len; k++) begin
        rd_addr = 3'($urandom_range(0, 7));
        step();
        start = 1'b0;
      end
    end
    $display("random phase: mask %h sig %h error %0d", seen_mask, signature, error);

    // Asynchronous reset mid-ARMED after three captures
    pulse_start();
    hold(3'd0, 8'h11, 5);
    hold(3'd1, 8'h22, 5);
    hold(3'd2, 8'h33, 5);
    check("pre_reset_mask", seen_mask, 8'h07);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_busy", {7'd0, busy},  8'h00);
    check("midreset_done", {7'd0, done},  8'h00);
    check("midreset_err",  {7'd0, error}, 8'h00);
    check("midreset_mask", seen_mask, 8'h00);
    check("midreset_sig",  signature, 8'h00);
    check("midreset_rd",   rd_data,   8'h00);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      step();
      check("post_reset_rd",   rd_data, 8'h00);
      check("post_reset_busy", {7'd0, busy}, 8'h00);
    end
    $display("mid reset: mask %h busy %0d", seen_mask, busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
